// File: rtl/conv_layer_input_if.sv
// Input-side pixel sequencer: loads one image row from the async ROM, then presents
// six adjacent pixels per kernel column. Optional ports behind `CONV_IN_VALID_EN.
module conv_layer_input_if #(
  parameter  int DATA_W = 32,
  parameter  int IMG_W  = 8,
  parameter  int OUT_W  = 6,
  parameter  int K      = 3,
  localparam int AW     = $clog2(IMG_W * IMG_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DATA_W-1:0]         pixel_in,
  output logic [AW-1:0]             rom_addr,
  output logic [DATA_W*OUT_W-1:0]   out_kernel_port,
`ifdef CONV_IN_VALID_EN
  output logic                      out_valid,
  output logic                      win_last,
`endif
  output logic [2:0]                current_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(OUT_W);
  localparam int KW = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_OUT  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       r_q, r_d, r_n;
  logic [KW-1:0]       kr_q, kr_d, kr_n;
  logic [CW-1:0]       col_q, col_d;
  logic [KW-1:0]       kc_q, kc_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]   line_q [IMG_W];
  logic                wr_en;
  logic                clr;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    kr_d    = kr_q;
    col_d   = col_q;
    kc_d    = kc_q;
    addr_d  = addr_q;
    r_n     = r_q;
    kr_n    = kr_q;
    wr_en   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!enable) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else begin
          wr_en = 1'b1;
          col_d = col_q + CW'(1);
          if (col_q == CW'(IMG_W - 1)) begin
            state_d = S_OUT;
            kc_d    = '0;
            col_d   = '0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_OUT: begin
        if (!enable) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else if (kc_q == KW'(K - 1)) begin
          state_d = S_NEXT;
          kc_d    = '0;
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      S_NEXT: begin
        if (!enable) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else if (r_q == RW'(OUT_W - 1) && kr_q == KW'(K - 1)) begin
          state_d = S_DONE;
        end else begin
          // kernel row wraps into the next output row
          if (kr_q == KW'(K - 1)) begin
            kr_n = '0;
            r_n  = r_q + RW'(1);
          end else begin
            kr_n = kr_q + KW'(1);
          end
          r_d     = r_n;
          kr_d    = kr_n;
          col_d   = '0;
          addr_d  = (AW'(r_n) + AW'(kr_n)) * AW'(IMG_W);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      r_d    = '0;
      kr_d   = '0;
      col_d  = '0;
      kc_d   = '0;
      addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      kr_q    <= '0;
      col_q   <= '0;
      kc_q    <= '0;
      addr_q  <= '0;
      for (int i = 0; i < IMG_W; i++) line_q[i] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      kr_q    <= kr_d;
      col_q   <= col_d;
      kc_q    <= kc_d;
      addr_q  <= addr_d;
      if (wr_en) line_q[col_q] <= pixel_in;
    end
  end

  // lane 0 occupies the most significant word
  always_comb begin
    out_kernel_port = '0;
    if (state_q == S_OUT) begin
      for (int k = 0; k < OUT_W; k++)
        out_kernel_port[DATA_W*(OUT_W-k)-1 -: DATA_W] = line_q[CW'(kc_q) + CW'(k)];
    end
  end

  assign rom_addr      = addr_q;
  assign current_state = state_q;

`ifdef CONV_IN_VALID_EN
  assign out_valid = (state_q == S_OUT);
  assign win_last  = (state_q == S_OUT) && (r_q == RW'(OUT_W - 1)) &&
                     (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
`endif

endmodule

// File: tb/tb_conv_layer_input_if.sv
// Bench for conv_layer_input_if: schedule-level reference model compared every cycle,
// directed scenarios with literal windows, then randomized enable/reset and ROM data.
module tb_conv_layer_input_if;
  localparam int DW       = 32;
  localparam int IW       = 8;
  localparam int NL       = 6;
  localparam int KK       = 3;
  localparam int PASS_CYC = IW + KK + 1;
  localparam int RUN_CYC  = NL * KK * PASS_CYC;
  localparam int OW       = DW * NL;

  localparam logic [OW-1:0] W_0_5   = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
  localparam logic [OW-1:0] W_2_7   = {32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
  localparam logic [OW-1:0] W_8_13  = {32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13};
  localparam logic [OW-1:0] W_58_63 = {32'd58, 32'd59, 32'd60, 32'd61, 32'd62, 32'd63};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] pixel_in;
  logic [5:0]    rom_addr;
  logic [OW-1:0] okp;
  logic [2:0]    cs;
`ifdef CONV_IN_VALID_EN
  logic          out_valid;
  logic          win_last;
`endif

  logic [DW-1:0] rom [IW*IW];
  assign pixel_in = rom[rom_addr];

  always #5 clk = ~clk;

  conv_layer_input_if dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .pixel_in        (pixel_in),
    .rom_addr        (rom_addr),
    .out_kernel_port (okp),
`ifdef CONV_IN_VALID_EN
    .out_valid       (out_valid),
    .win_last        (win_last),
`endif
    .current_state   (cs)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mode   = 0;   // 0 idle, 1 running (position t in schedule), 2 done
  int t      = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) mode = 0;
    else begin
      case (mode)
        0: if (enable) begin mode = 1; t = 0; end
        1: if (!enable) mode = 0;
           else if (t == RUN_CYC - 1) mode = 2;
           else t++;
        default: if (!enable) mode = 0;
      endcase
    end
  endtask

  task automatic compare();
    logic [2:0]    e_st;
    logic [5:0]    e_addr;
    logic [OW-1:0] e_k;
    logic          e_last;
    int p, o, row;
    e_st = 3'd0; e_addr = 6'd0; e_k = '0; e_last = 1'b0;
    if (mode == 2) begin
      e_st   = 3'd4;
      e_addr = 6'(IW * IW - 1);
    end else if (mode == 1) begin
      p   = t / PASS_CYC;
      o   = t % PASS_CYC;
      row = p / KK + p % KK;
      if (o < IW) begin
        e_st   = 3'd1;
        e_addr = 6'(row * IW + o);
      end else begin
        e_addr = 6'(row * IW + IW - 1);
        if (o < IW + KK) begin
          e_st = 3'd2;
          for (int k = 0; k < NL; k++)
            e_k[DW*(NL-k)-1 -: DW] = rom[row * IW + (o - IW) + k];
          e_last = (t == RUN_CYC - 2);
        end else begin
          e_st = 3'd3;
        end
      end
    end
    chk("state", OW'(cs), OW'(e_st));
    chk("addr", OW'(rom_addr), OW'(e_addr));
    chk("kernel", okp, e_k);
`ifdef CONV_IN_VALID_EN
    chk("out_valid", OW'(out_valid), OW'(e_st == 3'd2));
    chk("win_last", OW'(win_last), OW'(e_last));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  initial begin
    int busy, outs, loads;
    logic [2:0]    prev;
    logic [OW-1:0] last_win;
    for (int a = 0; a < IW * IW; a++) rom[a] = DW'(a);
    rst = 1'b1; enable = 1'b0;
    tick(); tick();
    chk("rst_state", OW'(cs), OW'(0));
    chk("rst_addr", OW'(rom_addr), OW'(0));
    chk("rst_kernel", okp, '0);

    // full run with identity ROM
    rst = 1'b0; enable = 1'b1;
    busy = 0; outs = 0; loads = 0; prev = 3'd0; last_win = '0;
    for (int i = 0; i < 300 && cs != 3'd4; i++) begin
      tick();
      if (cs == 3'd1 || cs == 3'd2 || cs == 3'd3) busy++;
      if (cs == 3'd2) begin outs++; last_win = okp; end
      if (cs == 3'd1 && prev != 3'd1) loads++;
      prev = cs;
      if (cs != 3'd4) begin
        if (busy == 1)  chk("first_addr", OW'(rom_addr), OW'(0));
        if (busy == 9)  chk("win_r0_kr0_kc0", okp, W_0_5);
        if (busy == 11) chk("win_r0_kr0_kc2", okp, W_2_7);
        if (busy == 13) chk("pass2_addr", OW'(rom_addr), OW'(8));
        if (busy == 21) chk("win_r0_kr1_kc0", okp, W_8_13);
      end
    end
    chk("done_reached", OW'(cs), OW'(4));
    chk("busy_cycles", OW'(busy), OW'(216));
    chk("out_cycles", OW'(outs), OW'(54));
    chk("load_bursts", OW'(loads), OW'(18));
    chk("last_window", last_win, W_58_63);
    repeat (4) tick();
    chk("done_hold", OW'(cs), OW'(4));

    // leave DONE for one cycle and restart
    enable = 1'b0; tick();
    chk("done_to_idle", OW'(cs), OW'(0));
    enable = 1'b1;
    repeat (9) tick();
    chk("restart_win", okp, W_0_5);

    // abort in fourth LOAD cycle
    enable = 1'b0; tick();
    enable = 1'b1;
    repeat (4) tick();
    chk("abort_pre_addr", OW'(rom_addr), OW'(3));
    enable = 1'b0; tick();
    chk("abort_state", OW'(cs), OW'(0));
    chk("abort_addr", OW'(rom_addr), OW'(0));
    chk("abort_kernel", okp, '0);
    enable = 1'b1; tick();
    chk("reenable_state", OW'(cs), OW'(1));
    chk("reenable_addr", OW'(rom_addr), OW'(0));

    // reset during OUT with enable held
    for (int i = 0; i < 20 && cs != 3'd2; i++) tick();
    chk("reach_out", OW'(cs), OW'(2));
    rst = 1'b1; tick();
    chk("rst_out_state", OW'(cs), OW'(0));
    chk("rst_out_addr", OW'(rom_addr), OW'(0));
    chk("rst_out_kernel", okp, '0);
    rst = 1'b0; tick();
    chk("post_rst_state", OW'(cs), OW'(1));
    chk("post_rst_addr", OW'(rom_addr), OW'(0));

    // randomized ROM contents, enable drops and resets
    rst = 1'b1;
    for (int a = 0; a < IW * IW; a++) rom[a] = $urandom;
    tick();
    rst = 1'b0;
    repeat (4000) begin
      enable = ($urandom_range(0, 299) != 0);
      rst    = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
